// File: rtl/fifo_drain_arbiter.sv
// fifo_drain_arbiter
//   Round-robin scheduler that drains NUM_SRC FIFOs into one shared
//   downstream port. While a source is granted, one word is popped per cycle
//   whenever the single-entry output stage has room. A source gives up the
//   port when its FIFO runs dry or after MAX_BURST pops. The next scan always
//   starts just after the source that held the port last.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   src_empty  per-FIFO empty flags (bit i = FIFO i)
//   src_data   per-FIFO head words, FIFO i at [i*DATA_WIDTH +: DATA_WIDTH]
//   src_re     one-hot read enable to the granted FIFO (combinational)
//   out_valid  output stage holds a word
//   out_ready  downstream accepts the word this cycle
//   out_data   registered popped word
//   out_src    index of the FIFO that supplied out_data
//   busy       arbiter is in GRANT
module fifo_drain_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int IDX_W      = 2,
  parameter int MAX_BURST  = 4,
  parameter int CNT_W      = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_SRC-1:0]            src_empty,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  output logic [NUM_SRC-1:0]            src_re,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [IDX_W-1:0]              out_src,
  output logic                          busy
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t                state_r, state_n;
  logic [IDX_W-1:0]      grant_r, grant_n;
  logic [IDX_W-1:0]      last_grant_r, last_grant_n;
  logic [CNT_W-1:0]      burst_cnt_r, burst_cnt_n;
  logic                  out_valid_r;
  logic [DATA_WIDTH-1:0] out_data_r;
  logic [IDX_W-1:0]      out_src_r;

  logic [NUM_SRC-1:0]    grant_oh_s;
  logic                  grant_empty_s;
  logic                  space_s;
  logic                  pop_s;
  logic                  any_ready_s;
  logic [DATA_WIDTH-1:0] word_s;
  logic [IDX_W-1:0]      scan_s;

  // Decode the grant, select its head word and form the pop / read enable.
  always_comb begin
    grant_oh_s = '0;
    word_s     = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      grant_oh_s[i] = (grant_r == IDX_W'(i));
      word_s = word_s | (src_data[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant_oh_s[i]}});
    end
    grant_empty_s = |(src_empty & grant_oh_s);
    space_s       = !out_valid_r || out_ready;
    pop_s         = (state_r == GRANT) && !grant_empty_s && space_s;
    src_re        = pop_s ? grant_oh_s : {NUM_SRC{1'b0}};
    any_ready_s   = (src_empty != {NUM_SRC{1'b1}});
  end

  // Round-robin scan: first non-empty source after last_grant, wrapping.
  always_comb begin
    logic             found;
    logic             hit;
    logic [IDX_W-1:0] idx;
    found  = 1'b0;
    hit    = 1'b0;
    idx    = '0;
    scan_s = last_grant_r;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx    = IDX_W'((int'(last_grant_r) + k) % NUM_SRC);
      hit    = !found && !src_empty[idx];
      scan_s = hit ? idx : scan_s;
      found  = found || hit;
    end
  end

  // Next-state logic for the grant FSM, burst counter and rotation pointer.
  always_comb begin
    state_n      = state_r;
    grant_n      = grant_r;
    last_grant_n = last_grant_r;
    burst_cnt_n  = burst_cnt_r;
    case (state_r)
      IDLE: begin
        if (any_ready_s) begin
          grant_n     = scan_s;
          burst_cnt_n = '0;
          state_n     = GRANT;
        end else begin
          state_n = IDLE;
        end
      end
      GRANT: begin
        if (pop_s && (burst_cnt_r == CNT_W'(MAX_BURST - 1))) begin
          // quantum used up: hand the port on
          last_grant_n = grant_r;
          state_n      = IDLE;
        end else if (grant_empty_s) begin
          // empty flag lags the final pop by one cycle, so this also ends a drain
          last_grant_n = grant_r;
          state_n      = IDLE;
        end else if (pop_s) begin
          burst_cnt_n = burst_cnt_r + CNT_W'(1);
        end else begin
          state_n = GRANT;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // FSM and arbitration registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      grant_r      <= '0;
      last_grant_r <= IDX_W'(NUM_SRC - 1);
      burst_cnt_r  <= '0;
    end else begin
      state_r      <= state_n;
      grant_r      <= grant_n;
      last_grant_r <= last_grant_n;
      burst_cnt_r  <= burst_cnt_n;
    end
  end

  // Single-entry output stage; a pop may overwrite a word accepted this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_src_r   <= '0;
    end else if (pop_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= word_s;
      out_src_r   <= grant_r;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_src   = out_src_r;
  assign busy      = (state_r == GRANT);

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// tb_fifo_drain_arbiter
//   Directed and random stimulus for fifo_drain_arbiter. Source FIFOs are
//   modelled with queues (registered empty flag, head word shown
//   combinationally). Every pushed word also enters a per-source scoreboard;
//   each accepted output word must be the oldest outstanding word of the
//   source it claims.
module tb_fifo_drain_arbiter;

  localparam int NS  = 4;
  localparam int DW  = 8;
  localparam int MB  = 4;
  localparam int MAX_OTHER = (NS - 1) * MB;

  logic          clk;
  logic          rst_n;
  logic [NS-1:0] src_empty;
  logic [NS*DW-1:0] src_data;
  logic [NS-1:0] src_re;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    out_src;
  logic          busy;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] fq [NS][$];
  logic [DW-1:0] sb [NS][$];
  int other_pops [NS];
  int max_wait = 0;

  fifo_drain_arbiter #(
    .NUM_SRC(4), .DATA_WIDTH(8), .IDX_W(2), .MAX_BURST(4), .CNT_W(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .src_empty(src_empty), .src_data(src_data),
    .src_re(src_re), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_src(out_src), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic update_inputs();
    for (int i = 0; i < NS; i++) begin
      src_empty[i] = (fq[i].size() == 0);
      src_data[i*DW +: DW] = (fq[i].size() != 0) ? fq[i][0] : 8'h00;
    end
  endtask

  task automatic push(input int s, input logic [DW-1:0] w);
    fq[s].push_back(w);
    sb[s].push_back(w);
    update_inputs();
  endtask

  task automatic flush();
    for (int i = 0; i < NS; i++) begin
      fq[i].delete();
      sb[i].delete();
      other_pops[i] = 0;
    end
    update_inputs();
  endtask

  // One clock: sample at the falling edge, then apply FIFO pops after the
  // rising edge. Ends 2 time units after the rising edge.
  task automatic cycle();
    logic [NS-1:0] re;
    logic [NS-1:0] emp;
    logic          ov;
    logic          rdy;
    logic [DW-1:0] od;
    logic [1:0]    os;
    logic [DW-1:0] expw;
    @(negedge clk);
    re  = src_re;
    emp = src_empty;
    ov  = out_valid;
    rdy = out_ready;
    od  = out_data;
    os  = out_src;
    chk("re_onehot0", 32'($onehot0(re)), 32'd1);
    chk("re_to_empty", 32'(re & emp), 32'd0);
    if (ov && rdy) begin
      if (sb[os].size() == 0) begin
        chk("sb_unexpected_word", 32'd1, 32'd0);
      end else begin
        expw = sb[os].pop_front();
        chk("sb_order", 32'(od), 32'(expw));
      end
    end
    for (int s = 0; s < NS; s++) begin
      if (emp[s] || re[s]) other_pops[s] = 0;
      else if (re != '0) other_pops[s]++;
      if (other_pops[s] > max_wait) max_wait = other_pops[s];
    end
    @(posedge clk);
    #1;
    for (int s = 0; s < NS; s++) begin
      if (re[s] && fq[s].size() != 0) void'(fq[s].pop_front());
    end
    update_inputs();
    #1;
  endtask

  int exp_trace [18] = '{7, 0, 0, 0, 0, 7, 1, 1, 1, 1, 7, 0, 0, 7, 7, 1, 1, 7};

  initial begin
    int  total;
    logic done;
    rst_n     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < NS; i++) other_pops[i] = 0;
    update_inputs();
    @(posedge clk);
    #1;

    // ---- reset: FIFOs non-empty while held in reset
    push(0, 8'h10); push(0, 8'h11); push(0, 8'h12); push(1, 8'h30);
    repeat (3) begin
      cycle();
      chk("rst_src_re", 32'(src_re), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
    end
    rst_n = 1'b1;
    cycle();
    chk("first_grant_busy", 32'(busy), 32'd1);
    chk("first_grant_fifo0", 32'(src_re), 32'h1);
    cycle();
    chk("first_word_valid", 32'(out_valid), 32'd1);
    chk("first_word_data", 32'(out_data), 32'h10);
    chk("first_word_src", 32'(out_src), 32'd0);
    // mid-burst asynchronous reset, checked before the next clock edge
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", 32'(out_valid), 32'd0);
    chk("async_out_data", 32'(out_data), 32'd0);
    chk("async_out_src", 32'(out_src), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_src_re", 32'(src_re), 32'd0);
    flush();
    cycle();
    rst_n = 1'b1;
    cycle();
    chk("post_rst_idle", 32'(busy), 32'd0);

    // ---- single source, FIFO 2
    push(2, 8'hA1); push(2, 8'hA2); push(2, 8'hA3);
    cycle();
    chk("ss_grant_busy", 32'(busy), 32'd1);
    chk("ss_no_word_yet", 32'(out_valid), 32'd0);
    cycle();
    chk("ss_w1_valid", 32'(out_valid), 32'd1);
    chk("ss_w1_data", 32'(out_data), 32'hA1);
    chk("ss_w1_src", 32'(out_src), 32'd2);
    cycle();
    chk("ss_w2_data", 32'(out_data), 32'hA2);
    chk("ss_w2_src", 32'(out_src), 32'd2);
    cycle();
    chk("ss_w3_data", 32'(out_data), 32'hA3);
    chk("ss_w3_src", 32'(out_src), 32'd2);
    cycle();
    chk("ss_back_idle", 32'(busy), 32'd0);
    chk("ss_drained_valid", 32'(out_valid), 32'd0);

    // ---- burst rotation between FIFOs 0 and 1 (7 marks an empty output)
    for (int k = 0; k < 6; k++) begin
      push(0, 8'(8'h00 + k));
      push(1, 8'(8'h10 + k));
    end
    for (int k = 0; k < 18; k++) begin
      cycle();
      chk($sformatf("burst_trace_%0d", k), out_valid ? 32'(out_src) : 32'd7, 32'(exp_trace[k]));
    end

    // ---- backpressure on FIFO 3
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) push(3, 8'(8'hC0 + k));
    cycle();
    chk("bp_grant3", 32'(src_re), 32'h8);
    cycle();
    chk("bp_first_data", 32'(out_data), 32'hC0);
    chk("bp_first_valid", 32'(out_valid), 32'd1);
    chk("bp_stall_re", 32'(src_re), 32'd0);
    repeat (4) begin
      cycle();
      chk("bp_stall_re", 32'(src_re), 32'd0);
      chk("bp_stall_data", 32'(out_data), 32'hC0);
      chk("bp_stall_valid", 32'(out_valid), 32'd1);
    end
    chk("bp_one_pop", 32'(fq[3].size()), 32'd4);
    out_ready = 1'b1;
    cycle();
    chk("bp_r1_data", 32'(out_data), 32'hC1);
    cycle();
    chk("bp_r2_data", 32'(out_data), 32'hC2);
    cycle();
    chk("bp_r3_data", 32'(out_data), 32'hC3);
    cycle();
    chk("bp_quantum_bubble", 32'(out_valid), 32'd0);
    cycle();
    chk("bp_r5_data", 32'(out_data), 32'hC4);
    chk("bp_r5_src", 32'(out_src), 32'd3);
    cycle();
    chk("bp_done_idle", 32'(busy), 32'd0);

    // ---- wrap: last grant was 3, FIFOs 0 and 3 pending
    push(0, 8'hD0);
    push(3, 8'hE0);
    cycle();
    chk("wrap_grant0", 32'(src_re), 32'h1);
    cycle();
    chk("wrap_src0", 32'(out_src), 32'd0);
    chk("wrap_data0", 32'(out_data), 32'hD0);
    cycle();
    chk("wrap_bubble", 32'(out_valid), 32'd0);
    cycle();
    chk("wrap_grant3", 32'(src_re), 32'h8);
    cycle();
    chk("wrap_src3", 32'(out_src), 32'd3);
    chk("wrap_data3", 32'(out_data), 32'hE0);
    cycle();

    // ---- random soak
    for (int i = 0; i < NS; i++) other_pops[i] = 0;
    for (int n = 0; n < 3000; n++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      for (int s = 0; s < NS; s++) begin
        if ($urandom_range(0, 5) == 0 && fq[s].size() < 8) push(s, 8'($urandom));
      end
      cycle();
    end
    out_ready = 1'b1;
    done = 1'b0;
    for (int n = 0; n < 400 && !done; n++) begin
      cycle();
      done = (src_empty == 4'hF) && !out_valid;
    end
    chk("soak_drain_done", 32'(done), 32'd1);
    total = 0;
    for (int s = 0; s < NS; s++) total += sb[s].size();
    chk("soak_all_delivered", 32'(total), 32'd0);
    chk("soak_no_starvation", 32'(max_wait <= MAX_OTHER), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
